tile_config_loader: RTL
=======================

Name: tile_config_loader

Overview:
- Sequences configuration of a PE tile, or a chain of tiles sharing one config bus, from a 32-bit bitstream word stream.
- Parses a header (entry count) followed by (address, data) word pairs.
- Drives the shared config_addr/config_data bus that every tile's address matchers decode (tile_id in [15:0], module flag in [31:16]).
- Between writes it parks the bus on a null address, so no config enable (CLB, CB0, CB1, SB) is asserted spuriously.

Parameters:
- WRITE_CYCLES, 1: cycles each (addr, data) pair is held on the bus. Legal range 1..15.
- IDLE_MOD_ID, 0: module-flag value driven in config_addr[31:16] when idle. Must not equal any real flag (4..7).
- COUNT_W, 16: width of the entry-count header field and of entries_written.

Ports:
- clk  in  1  : system clock; all state on rising edge.
- reset  in  1  : asynchronous, active-low reset.
- start  in  1  : begin loading one bitstream. Sampled only in IDLE.
- bs_valid  in  1  : bitstream word valid.
- bs_data  in  32  : bitstream word.
- bs_ready  out  1  : loader accepts word. A transfer occurs when bs_valid && bs_ready at a rising edge.
- config_addr  out  32  : to tile config_addr bus. Registered.
- config_data  out  32  : to tile config_data bus. Registered.
- busy  out  1  : high in every state except IDLE.
- done  out  1  : one-cycle pulse at end of load.
- err  out  1  : sticky; set on an illegal entry; cleared by an accepted start.
- entries_written  out  COUNT_W  : writes issued in the current or last load.

Behaviour:
- Reset (reset=0, asynchronous) forces:
  - state=IDLE; bs_ready=0; busy=0; done=0; err=0; entries_written=0.
  - config_addr={IDLE_MOD_ID[15:0],16'h0}; config_data=0.
- All outputs are registered except bs_ready and busy, which are decoded from the state.
- States: IDLE, HDR, ADDR, DATA, WRITE, DONE.
- IDLE:
  - bs_ready=0.
  - start=1 -> HDR; clear err and entries_written.
  - start in any other state is ignored.
- HDR:
  - bs_ready=1. On transfer, remaining=bs_data[COUNT_W-1:0].
  - remaining==0 -> DONE; otherwise -> ADDR.
  - bs_data[31:COUNT_W] is ignored.
- ADDR: bs_ready=1. On transfer, latch addr_q -> DATA.
- DATA:
  - bs_ready=1. On transfer, latch data_q.
  - If addr_q[31:16]==IDLE_MOD_ID: illegal entry. Set err, skip the write, decrement remaining, go to ADDR (or DONE if remaining becomes 0).
  - Otherwise: load the hold counter with WRITE_CYCLES-1, and on the same edge drive config_addr<=addr_q and config_data<=bs_data. Go to WRITE.
- WRITE:
  - bs_ready=0. Bus holds addr/data for exactly WRITE_CYCLES cycles, starting the cycle after the DATA-word transfer edge.
  - When the counter reaches 0, on that edge:
    - config_addr returns to the idle address and config_data to 0.
    - entries_written++ and remaining--.
    - Next state: DONE if remaining==0, else ADDR.
- DONE: done=1 for exactly one cycle -> IDLE. err and entries_written hold until the next accepted start.
- Throughput: with back-to-back bs_valid and WRITE_CYCLES=1, each entry takes 3 cycles (ADDR, DATA, WRITE). Header takes 1 cycle; DONE takes 1 cycle.
- bs_valid gaps stall the loader in HDR/ADDR/DATA with the bus idle. No timeout.
- entries_written saturates at 2^COUNT_W-1; it cannot overflow, since count is at most that value.
- Reset asserted mid-WRITE: the bus returns to the idle address immediately and asynchronously. The partial write is lost; the tile sees the enable deassert.

Decomposition:
- Package tile_cfg_pkg holds:
  - field constants: MOD_ID_LSB=16, MOD_ID_MSB=31, TILE_ID_LSB=0, TILE_ID_MSB=15;
  - module flags: FLAG_CLB=4, FLAG_CB1=5, FLAG_CB0=6, FLAG_SB=7;
  - IDLE_MOD_ID default;
  - loader state enum.
- One natural sub-module: cfg_hold_timer, a 4-bit down-counter with load, dec and zero flag, used for WRITE_CYCLES.

Test Plan:
- Header 0x0000_0000: done pulses one cycle after the header transfer. config_addr stays 0x0000_0000 throughout; entries_written=0; err=0.
- Header 1, addr 0x0004_0003, data 0x2, WRITE_CYCLES=1:
  - config_addr=0x0004_0003 and config_data=0x2 for exactly 1 cycle, then 0x0000_0000/0.
  - A tile_id=3 CLB matcher pulses once; entries_written=1; done pulses.
- Header 3 with randomized bs_valid gaps, entries (0x0006_0001,0x5), (0x0005_0001,0x3), (0x0007_0001,0xAA):
  - bus shows them in order, each for WRITE_CYCLES;
  - bs_ready=0 during every WRITE cycle;
  - entries_written=3.
- Header 2, entry 1 addr 0x0000_0009 (illegal), entry 2 addr 0x0004_0009 data 0x1:
  - err=1; only entry 2 appears on the bus; entries_written=1; done pulses.
- WRITE_CYCLES=3, header 1: the bus holds the entry for exactly 3 cycles. start pulsed during WRITE is ignored; after done, a new start clears err and entries_written.
- Reset driven low mid-WRITE, asynchronously: config_addr=0 and busy=0 in the same cycle. After release the loader sits in IDLE with bs_ready=0 until start.

Source files
------------

// File: rtl/tile_cfg_pkg.sv
// Shared constants for the tile configuration bus: address field layout,
// module flags decoded by the tile address matchers, and loader states.
package tile_cfg_pkg;

    localparam int MOD_ID_LSB  = 16;
    localparam int MOD_ID_MSB  = 31;
    localparam int TILE_ID_LSB = 0;
    localparam int TILE_ID_MSB = 15;

    localparam logic [15:0] FLAG_CLB = 16'd4;
    localparam logic [15:0] FLAG_CB1 = 16'd5;
    localparam logic [15:0] FLAG_CB0 = 16'd6;
    localparam logic [15:0] FLAG_SB  = 16'd7;

    localparam int unsigned IDLE_MOD_ID_DEFAULT = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_ADDR,
        S_DATA,
        S_WRITE,
        S_DONE
    } loader_state_t;

endpackage

// File: rtl/cfg_hold_timer.sv
// 4-bit down-counter that times how long one config write stays on the bus.
module cfg_hold_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] load_value,
    input  logic       dec,
    output logic       zero
);

    logic [3:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= 4'd0;
        end else if (load) begin
            count <= load_value;
        end else if (dec) begin
            count <= count - 4'd1;
        end
    end

    assign zero = (count == 4'd0);

endmodule

// File: rtl/tile_config_loader.sv
// Parses a bitstream (entry-count header, then address/data pairs) and drives
// the shared tile config bus, parking it on a null address between writes.
module tile_config_loader
    import tile_cfg_pkg::*;
#(
    parameter int unsigned WRITE_CYCLES = 1,
    parameter int unsigned IDLE_MOD_ID  = IDLE_MOD_ID_DEFAULT,
    parameter int unsigned COUNT_W      = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               bs_valid,
    input  logic [31:0]        bs_data,
    output logic               bs_ready,
    output logic [31:0]        config_addr,
    output logic [31:0]        config_data,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [COUNT_W-1:0] entries_written,
    output loader_state_t      dbg_state
);

    // Bitstream handshake: a word moves when bs_valid && bs_ready at a rising
    // edge; bs_ready is high only in HDR/ADDR/DATA, bs_data must hold while stalled.

    localparam logic [15:0]        IDLE_FLAG = 16'(IDLE_MOD_ID);
    localparam logic [31:0]        IDLE_ADDR = {IDLE_FLAG, 16'h0000};
    localparam logic [3:0]         HOLD_LOAD = 4'(WRITE_CYCLES - 1);
    localparam logic [COUNT_W-1:0] ONE       = COUNT_W'(1);
    localparam logic [COUNT_W-1:0] EW_MAX    = '1;

    loader_state_t      state_q, state_d;
    logic [COUNT_W-1:0] remaining;
    logic [31:0]        addr_q;
    logic               xfer, illegal, last_entry;
    logic               hold_load, hold_dec, hold_zero;

    assign xfer       = bs_valid && bs_ready;
    assign illegal    = (addr_q[MOD_ID_MSB:MOD_ID_LSB] == IDLE_FLAG);
    assign last_entry = (remaining == ONE);
    assign bs_ready   = (state_q == S_HDR) || (state_q == S_ADDR) || (state_q == S_DATA);
    assign busy       = (state_q != S_IDLE);
    assign dbg_state  = state_q;

    cfg_hold_timer u_hold (
        .clk        (clk),
        .reset      (reset),
        .load       (hold_load),
        .load_value (HOLD_LOAD),
        .dec        (hold_dec),
        .zero       (hold_zero)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        hold_load = 1'b0;
        hold_dec  = 1'b0;
        case (state_q)
            S_IDLE:  if (start) state_d = S_HDR;
            S_HDR:   if (xfer) state_d = (bs_data[COUNT_W-1:0] == '0) ? S_DONE : S_ADDR;
            S_ADDR:  if (xfer) state_d = S_DATA;
            S_DATA: begin
                if (xfer) begin
                    if (illegal) begin
                        state_d = last_entry ? S_DONE : S_ADDR;
                    end else begin
                        hold_load = 1'b1;
                        state_d   = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                if (hold_zero) state_d = last_entry ? S_DONE : S_ADDR;
                else           hold_dec = 1'b1;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // The bus is driven straight from registers so reset parks it asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            config_addr     <= IDLE_ADDR;
            config_data     <= '0;
            done            <= 1'b0;
            err             <= 1'b0;
            entries_written <= '0;
            remaining       <= '0;
            addr_q          <= '0;
        end else begin
            done <= (state_d == S_DONE);
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        err             <= 1'b0;
                        entries_written <= '0;
                    end
                end
                S_HDR:  if (xfer) remaining <= bs_data[COUNT_W-1:0];
                S_ADDR: if (xfer) addr_q <= bs_data;
                S_DATA: begin
                    if (xfer) begin
                        if (illegal) begin
                            err       <= 1'b1;
                            remaining <= remaining - ONE;
                        end else begin
                            config_addr <= addr_q;
                            config_data <= bs_data;
                        end
                    end
                end
                S_WRITE: begin
                    if (hold_zero) begin
                        config_addr <= IDLE_ADDR;
                        config_data <= '0;
                        remaining   <= remaining - ONE;
                        if (entries_written != EW_MAX) entries_written <= entries_written + ONE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
